// File: rtl/xor_parity_accum.sv
// -----------------------------------------------------------------------------
// xor_parity_accum
//
// Streaming parity engine. Each accepted WIDTH-bit word is XOR-reduced to one
// bit and folded into a running frame parity. A frame ends on a word flagged
// with in_last, or is force-closed when it reaches MAX_WORDS words. Each closed
// frame yields one registered result on the output handshake.
//
// Parameters
//   WIDTH      bits per input word (>=1)
//   MAX_WORDS  maximum words per frame; the frame is force-closed at this count
//   ODD        0: even parity (XOR of all bits), 1: odd parity (inverted)
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     input word valid
//   in_ready     block can accept a word (high only while accumulating)
//   in_data      input word
//   in_last      last word of the frame (qualified by in_valid & in_ready)
//   out_valid    frame result valid
//   out_ready    consumer accepts the result
//   out_parity   frame parity
//   out_count    words in the frame (1..MAX_WORDS)
//   out_trunc    frame was closed by MAX_WORDS rather than by in_last
//
// Optional feature (macro PARITY_CHECK_EN)
//   in_parity    expected parity, sampled with the closing word
//   out_err      in_parity != out_parity, registered and held with out_valid
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. While valid is high and ready low, the producer holds its payload
// stable. in_ready and out_valid are decoded from the state register, so
// neither depends combinationally on any input.
// -----------------------------------------------------------------------------
module xor_parity_accum #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    parameter int ODD       = 0,
    localparam int CNT_W    = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
`ifdef PARITY_CHECK_EN
    input  logic             in_parity,
    output logic             out_err,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc
);

    localparam logic ODD_BIT = (ODD != 0);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic             acc, acc_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             par_q, par_next;
    logic [CNT_W-1:0] count_q, count_next;
    logic             trunc_q, trunc_next;
`ifdef PARITY_CHECK_EN
    logic             err_q, err_next;
`endif

    logic             word_par;
    logic [CNT_W-1:0] cnt_inc;
    logic             at_max;
    logic             accept;
    logic             frame_par;

    assign word_par  = ^in_data;
    assign cnt_inc   = cnt + CNT_W'(1);
    assign at_max    = (cnt_inc == CNT_W'(MAX_WORDS));
    assign accept    = in_valid & in_ready;
    assign frame_par = acc ^ word_par ^ ODD_BIT;

    assign in_ready   = (state == ACCUM);
    assign out_valid  = (state == HOLD);
    assign out_parity = par_q;
    assign out_count  = count_q;
    assign out_trunc  = trunc_q;
`ifdef PARITY_CHECK_EN
    assign out_err    = err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACCUM;
            acc     <= 1'b0;
            cnt     <= '0;
            par_q   <= 1'b0;
            count_q <= '0;
            trunc_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            cnt     <= cnt_next;
            par_q   <= par_next;
            count_q <= count_next;
            trunc_q <= trunc_next;
`ifdef PARITY_CHECK_EN
            err_q   <= err_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        par_next   = par_q;
        count_next = count_q;
        trunc_next = trunc_q;
`ifdef PARITY_CHECK_EN
        err_next   = err_q;
`endif
        case (state)
            ACCUM: begin
                if (accept) begin
                    if (in_last || at_max) begin
                        // Close the frame: publish the result and restart the
                        // accumulator so the next frame begins from zero.
                        state_next = HOLD;
                        par_next   = frame_par;
                        count_next = cnt_inc;
                        trunc_next = at_max & ~in_last;
                        acc_next   = 1'b0;
                        cnt_next   = '0;
`ifdef PARITY_CHECK_EN
                        err_next   = (in_parity != frame_par);
`endif
                    end else begin
                        acc_next = acc ^ word_par;
                        cnt_next = cnt_inc;
                    end
                end
            end
            HOLD: begin
                // in_ready is low here, so a word offered in the handshake
                // cycle waits one cycle: a single bubble per frame.
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

endmodule
